// File: rtl/typhoon_pkg.sv
// Shared framebuffer geometry, pixel type and tile-streamer FSM states.
package typhoon_pkg;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PAGE_WORDS = SCREEN_W * SCREEN_H;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WRITE,
        DONE
    } stream_state_t;
endpackage

// File: rtl/tile_addr_gen.sv
// Tile walk address generator: px/py counters, row base address,
// visibility clip and end-of-tile flag. Driven by load/setup/advance strobes.
module tile_addr_gen #(
    parameter int tileDim  = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          setup,
    input  logic          advance,
    input  logic [9:0]    x_off,
    input  logic [9:0]    y_off,
    input  logic          page,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic [19:0]   pix_addr,
    output logic          visible,
    output logic          fin
);
    logic [9:0]  x_q, y_q;
    logic        page_q;
    logic [19:0] row_addr, page_base, row_mul, y_w;
    logic [10:0] x_pix, y_pix;
    logic        px_last, py_last;

    assign y_w       = 20'(y_q);
    assign page_base = page_q ? 20'(SCREEN_W * SCREEN_H) : 20'd0;
    // 640 = 512 + 128, so the row multiply is two shifts and an add
    assign row_mul   = (SCREEN_W == 640) ? (y_w << 9) + (y_w << 7) : y_w * 20'(SCREEN_W);
    assign px_last   = (px == CW'(tileDim - 1));
    assign py_last   = (py == CW'(tileDim - 1));
    // 11-bit compare so tiles hanging off the right/bottom edge clip correctly
    assign x_pix     = 11'(x_q) + 11'(px);
    assign y_pix     = 11'(y_q) + 11'(py);
    assign visible   = (x_pix < 11'(SCREEN_W)) && (y_pix < 11'(SCREEN_H));
    assign pix_addr  = row_addr + 20'(px);

    // Latch origin on load, form the row base on setup, then walk row-major
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            page_q   <= 1'b0;
            px       <= '0;
            py       <= '0;
            row_addr <= '0;
            fin      <= 1'b0;
        end else if (load) begin
            x_q    <= x_off;
            y_q    <= y_off;
            page_q <= page;
            px     <= '0;
            py     <= '0;
            fin    <= 1'b0;
        end else if (setup) begin
            row_addr <= page_base + row_mul + 20'(x_q);
        end else if (advance) begin
            if (px_last) begin
                px       <= '0;
                row_addr <= row_addr + 20'(SCREEN_W);
                if (py_last) fin <= 1'b1;
                else         py  <= py + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
        end
    end
endmodule

// File: rtl/tile_stream_writer.sv
// Streams one finished tile from the selected rasterizer buffer into the
// framebuffer SRAM as req/grant word writes, clipping off-screen pixels.
module tile_stream_writer #(
    parameter int tileDim  = 8,
    parameter int SCREEN_W = typhoon_pkg::SCREEN_W,
    parameter int SCREEN_H = typhoon_pkg::SCREEN_H
) (
    input  logic                                 BOARD_CLK,
    input  logic                                 RESET_N,
    input  logic                                 streamTileTrigger,
    input  logic                                 streamingTileID,
    input  logic [9:0]                           xOffset,
    input  logic [9:0]                           yOffset,
    input  logic                                 drawPage,
    input  logic [tileDim-1:0][tileDim-1:0][15:0] cBufferTile0,
    input  logic [tileDim-1:0][tileDim-1:0][15:0] cBufferTile1,
    output logic                                 wr_req,
    output logic [19:0]                          wr_addr,
    output logic [15:0]                          wr_data,
    input  logic                                 wr_grant,
    output logic                                 doneStreaming,
    output logic                                 droppedTrigger
);
    import typhoon_pkg::*;

    localparam int CW = (tileDim > 1) ? $clog2(tileDim) : 1;

    stream_state_t state_q, state_d;
    logic          tile_id_q;
    logic          load, setup, advance, issue, slot_free;
    logic          visible, fin;
    logic [CW-1:0] px, py;
    logic [19:0]   pix_addr;
    pixel_t        tile_pix;

    // Tile contents are read live; upstream holds the buffer until done
    assign tile_pix      = tile_id_q ? cBufferTile1[px][py] : cBufferTile0[px][py];
    // Output register may take a new pixel when empty or being granted now
    assign slot_free     = !wr_req || wr_grant;
    assign issue         = (state_q == WRITE) && !fin && visible && slot_free;
    assign doneStreaming = (state_q == IDLE);

    tile_addr_gen #(
        .tileDim (tileDim),
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .CW      (CW)
    ) u_addr (
        .clk     (BOARD_CLK),
        .rst_n   (RESET_N),
        .load    (load),
        .setup   (setup),
        .advance (advance),
        .x_off   (xOffset),
        .y_off   (yOffset),
        .page    (drawPage),
        .px      (px),
        .py      (py),
        .pix_addr(pix_addr),
        .visible (visible),
        .fin     (fin)
    );

    // FSM state register
    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and walk strobes; clipped pixels skip without waiting on the slot
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        setup   = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (streamTileTrigger) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                setup   = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                advance = !fin && (!visible || slot_free);
                if (fin && slot_free) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tile select latch and sticky dropped-trigger flag
    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tile_id_q      <= 1'b0;
            droppedTrigger <= 1'b0;
        end else begin
            if (load) tile_id_q <= streamingTileID;
            if (streamTileTrigger && state_q != IDLE) droppedTrigger <= 1'b1;
        end
    end

    // Request register: holds addr/data until granted, reloads on the grant cycle
    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (wr_req && wr_grant) wr_req <= 1'b0;
            if (issue) begin
                wr_req  <= 1'b1;
                wr_addr <= pix_addr;
                wr_data <= tile_pix;
            end
        end
    end
endmodule

// File: tb/tb_tile_stream_writer.sv
// Scoreboard bench for tile_stream_writer: a reference model pushes the
// expected (addr, data) writes per tile; a monitor pops on each grant.
module tb_tile_stream_writer;
    logic                   BOARD_CLK = 1'b0;
    logic                   RESET_N = 1'b0;
    logic                   streamTileTrigger = 1'b0;
    logic                   streamingTileID = 1'b0;
    logic [9:0]             xOffset = '0, yOffset = '0;
    logic                   drawPage = 1'b0;
    logic [7:0][7:0][15:0]  buf0, buf1;
    logic                   wr_req;
    logic [19:0]            wr_addr;
    logic [15:0]            wr_data;
    logic                   wr_grant = 1'b0;
    logic                   doneStreaming, droppedTrigger;

    typedef struct { logic [19:0] a; logic [15:0] d; } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, writes = 0;
    int grant_pct = 100;
    int first_req = -1, last_req = -1;
    bit hold_chk = 0;
    bit exp_dropped = 0;
    logic [19:0] h_addr;
    logic [15:0] h_data;

    tile_stream_writer #(.tileDim(8)) dut (
        .BOARD_CLK(BOARD_CLK), .RESET_N(RESET_N),
        .streamTileTrigger(streamTileTrigger), .streamingTileID(streamingTileID),
        .xOffset(xOffset), .yOffset(yOffset), .drawPage(drawPage),
        .cBufferTile0(buf0), .cBufferTile1(buf1),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
        .doneStreaming(doneStreaming), .droppedTrigger(droppedTrigger)
    );

    always #10 BOARD_CLK = ~BOARD_CLK;
    always @(posedge BOARD_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every on-screen pixel of the tile, row-major
    function automatic int push_expected(input bit id, input int xo, input int yo, input bit page);
        int n = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                int sx = xo + x;
                int sy = yo + y;
                if (sx < 640 && sy < 480) begin
                    exp_t e;
                    e.a = 20'(page * 307200 + sy * 640 + sx);
                    e.d = id ? buf1[x][y] : buf0[x][y];
                    exp_q.push_back(e);
                    n++;
                end
            end
        return n;
    endfunction

    // Monitor: drives grant for the next edge, checks hold stability and accepted writes
    initial begin
        logic g;
        exp_t e;
        forever begin
            @(negedge BOARD_CLK);
            if (hold_chk) begin
                checks++;
                if (!wr_req || wr_addr != h_addr || wr_data != h_data) begin
                    errors++;
                    $display("FAIL hold: req=%0b addr=%0d data=%0h expected req=1 addr=%0d data=%0h",
                             wr_req, wr_addr, wr_data, h_addr, h_data);
                end
            end
            g = ($urandom_range(99) < grant_pct);
            wr_grant = g;
            if (wr_req) begin
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
            end
            if (wr_req && g) begin
                checks++;
                writes++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected addr=%0d data=%0h, none expected", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr != e.a || wr_data != e.d) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 wr_addr, wr_data, e.a, e.d);
                    end
                end
            end
            hold_chk = wr_req && !g;
            h_addr   = wr_addr;
            h_data   = wr_data;
        end
    end

    task automatic run_tile(input bit id, input int xo, input int yo, input bit page,
                            input int gpct, input bit timing, input int extra_at, input int rst_at);
        int nexp, t0, w0, done_cyc, budget;
        bit aborted;
        @(negedge BOARD_CLK);
        grant_pct       = gpct;
        streamingTileID = id;
        xOffset         = 10'(xo);
        yOffset         = 10'(yo);
        drawPage        = page;
        nexp            = push_expected(id, xo, yo, page);
        first_req       = -1;
        last_req        = -1;
        w0              = writes;
        streamTileTrigger = 1'b1;
        t0 = cyc + 1;
        @(negedge BOARD_CLK);
        streamTileTrigger = 1'b0;
        chk("busy_after_trigger", doneStreaming, 0);
        done_cyc = -1;
        aborted  = 0;
        budget   = 0;
        while (1) begin
            if (doneStreaming) begin
                done_cyc = cyc;
                break;
            end
            if (rst_at > 0 && cyc == t0 + rst_at - 1) begin
                #2;
                RESET_N  = 1'b0;
                hold_chk = 0;
                #1;
                chk("reset_req_drop", wr_req, 0);
                chk("reset_done", doneStreaming, 1);
                chk("reset_dropped", droppedTrigger, 0);
                exp_q.delete();
                exp_dropped = 0;
                repeat (3) @(posedge BOARD_CLK);
                @(negedge BOARD_CLK);
                RESET_N = 1'b1;
                aborted = 1;
                break;
            end
            if (budget++ > 2000) begin
                chk("done_timeout", 0, 1);
                break;
            end
            streamTileTrigger = (extra_at > 0 && cyc == t0 + extra_at - 1);
            @(negedge BOARD_CLK);
        end
        streamTileTrigger = 1'b0;
        if (aborted) return;
        if (extra_at > 0) exp_dropped = 1;
        chk("queue_drained", exp_q.size(), 0);
        chk("write_count", writes - w0, nexp);
        chk("dropped_flag", droppedTrigger, int'(exp_dropped));
        if (timing) begin
            chk("first_req_edge", first_req - t0, 2);
            chk("last_req_edge", last_req - t0, 65);
            chk("done_edge", done_cyc - t0, 67);
        end
        if (extra_at > 0) begin
            repeat (20) @(negedge BOARD_CLK);
            chk("no_second_tile", writes - w0, nexp);
            chk("idle_after_drop", doneStreaming, 1);
        end
    endtask

    task automatic rand_bufs();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                buf0[x][y] = 16'($urandom);
                buf1[x][y] = 16'($urandom);
            end
    endtask

    initial begin
        int xo, yo;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                buf0[x][y] = 16'(x + 8 * y);
                buf1[x][y] = 16'($urandom);
            end
        repeat (3) @(negedge BOARD_CLK);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_done", doneStreaming, 1);
        chk("rst_dropped", droppedTrigger, 0);
        RESET_N = 1'b1;
        repeat (2) @(negedge BOARD_CLK);

        run_tile(0, 0, 0, 0, 100, 1, 0, 0);          // ramp tile, latency
        run_tile(1, 632, 472, 1, 100, 0, 0, 0);      // last tile of page 1
        rand_bufs();
        run_tile(0, 636, 476, 0, 100, 0, 0, 0);      // 16 visible pixels
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) buf0[x][y] = 16'(x + 8 * y);
        run_tile(0, 0, 0, 0, 30, 0, 0, 0);           // backpressure
        run_tile(1, 100, 50, 0, 100, 0, 10, 0);      // trigger while busy
        run_tile(0, 0, 0, 0, 100, 0, 0, 20);         // reset mid-tile
        repeat (2) @(negedge BOARD_CLK);
        run_tile(0, 0, 0, 0, 100, 1, 0, 0);          // clean tile after reset

        for (int i = 0; i < 6; i++) begin
            rand_bufs();
            xo = ($urandom_range(1) == 1) ? 600 + $urandom_range(39) : $urandom_range(639);
            yo = ($urandom_range(1) == 1) ? 440 + $urandom_range(39) : $urandom_range(479);
            run_tile(1'($urandom_range(1)), xo, yo, 1'($urandom_range(1)),
                     20 + $urandom_range(80), 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
